mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Bus-side responder for the RISCV32I CPU memory port: serves the CPU's byte-wide address/data/write bus with 2^ADDR_WIDTH bytes of synchronous RAM plus the memory-mapped I/O window at 0x30000. Reads complete one cycle after the address (the CPU's 2-cycle read), writes complete in the issuing cycle. Input and output byte streams (UART side) are buffered in FIFOs. The block drives the CPU's ready input, stalling it when output buffering is full.

## Interface
- ADDR_WIDTH, 17: RAM address bits; RAM size 2^ADDR_WIDTH bytes.
- FIFO_AW, 4: log2 depth of each of the RX and TX FIFOs.
- clk_in  in  1  clock; all logic on rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- cpu_a  in  32  byte address from CPU; only [17:0] decoded.
- cpu_wdata  in  8  write data from CPU.
- cpu_wr  in  1  1 = write, 0 = read (every non-write cycle is a read).
- cpu_rdata  out  8  read data to CPU, valid the cycle after the address.
- cpu_rdy  out  1  CPU ready; low pauses the CPU.
- rx_data  in  8  input byte stream data.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  RX FIFO not full.
- tx_data  out  8  output byte stream data (TX FIFO head).
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  sink accepts tx_data.
- prog_stop  out  1  sticky; program has written 0x30004.

## Operation
- Decode: cpu_a[17:16]==2'b11 is I/O; anything else is RAM at cpu_a[ADDR_WIDTH-1:0].
- Bus action (RAM write, FIFO push/pop, snapshot load) happens only in cycles with cpu_rdy=1. In cpu_rdy=0 cycles there is no action and cpu_rdata holds.
- RAM write: mem[a] <= cpu_wdata. RAM read: cpu_rdata <= mem[a]. RAM is not cleared by reset.
- 0x30000 read: pops RX FIFO; cpu_rdata <= head. When empty, returns 0x00 with no pop. The CPU presents each I/O read address for exactly one rdy cycle per byte.
- 0x30000 write: pushes cpu_wdata to TX FIFO; 0x00 is ignored.
- 0x30004 write: sets prog_stop and pushes 0x00 to TX FIFO. Further writes push another 0x00.
- 0x30004..0x30007 read: returns byte a[1:0] of the 32-bit cycle counter, little-endian.
  - Reading 0x30004 returns cnt[7:0] and latches cnt[31:8] into snap.
  - 0x30005..0x30007 return the snap bytes, so a 4-byte sequence is coherent.
- Other I/O addresses: reads return 0x00; writes are ignored.
- Cycle counter: 32-bit, +1 every cycle out of reset (including cpu_rdy=0 cycles); wraps 0xFFFFFFFF→0.
- RX FIFO: push when rx_valid&&rx_ready.
- TX FIFO: pop when tx_valid&&tx_ready.
- cpu_rdy = !tx_full, driven combinationally from registered count.

## Timing
- Reset (rst_n_in low, asynchronous):
  - cpu_rdata=0x00, prog_stop=0, counter=0, snap=0.
  - Both FIFOs empty, so tx_valid=0, rx_ready=1, cpu_rdy=1.
  - RAM contents are preserved.
  - A reset mid-access aborts it; no partial write occurs.
- Read latency: address in cycle N → cpu_rdata valid in N+1 and held until the next rdy read.
- Write latency: takes effect at the end of cycle N. A read of the same address in N+1 sees the new data in N+2.
- TX full: cpu_rdy=0 from the cycle after the push that fills it. It returns to 1 the cycle after a pop.
- TX simultaneous push and pop: count unchanged; push order is preserved.
- RX simultaneous push and pop:
  - Not empty: count unchanged.
  - Empty: the read returns 0x00 and the pushed byte stays in the FIFO.
- RX full: rx_ready=0; pushes are not accepted until after a pop.
- Pointer wrap: FIFO pointers are FIFO_AW+1 bits. Full means equal low bits with differing MSB.

## Configuration
- MEM_IO_RESPONDER_CLK_CNT_EN defined: cycle counter and snap are implemented as above.
- Not defined: no counter or snap registers; reads of 0x30004..0x30007 return 0x00. The 0x30004 write/stop behaviour is unchanged.

## Test plan
- RAM write/read: write 0xA5 to 0x00123, then read 0x00123 → cpu_rdata=0xA5 one cycle after the read address; 0x1FFFF round-trips 0x3C.
- RX path: push 0x41,0x42 on rx, then read 0x30000 three times → 0x41, 0x42, 0x00; rx_ready stays 1.
- TX backpressure: tx_ready=0, write 0x30000 with 1..16 (FIFO_AW=4) → cpu_rdy=0 after 16th push.
  - A 17th write while rdy=0 is dropped.
  - Set tx_ready=1 → tx_data streams 1..16 in order and cpu_rdy returns to 1.
- Zero filter/stop: write 0x00 to 0x30000 → no tx_valid. Write 0x30004 → prog_stop=1 and tx_data=0x00.
- Counter coherence (macro on): force counter to 0x000000FE, read 0x30004..0x30007 on consecutive cycles → 0xFE, 0x00, 0x00, 0x00; macro off → all 0x00.
- Async reset mid-stream: assert rst_n_in with 3 bytes in TX → tx_valid=0 and prog_stop=0 immediately. A RAM byte written before reset still reads back correctly.

Source files
------------

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped UART FIFOs and cycle counter behind the RISCV32I memory port.
// Optional cycle counter/snapshot at 0x30004..0x30007 is built when MEM_IO_RESPONDER_CLK_CNT_EN is defined.

// Streams (rx_*, tx_*): a byte moves on a rising edge where valid && ready; valid never depends on ready.
module mem_io_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    logic [7:0]  store [2**AW];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prog_stop
);
    logic [7:0]            mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [15:0]           io_off;
    logic                  is_io;
    logic                  act;
    logic                  ram_we;
    logic                  io_wr;
    logic                  io_rd;
    logic                  tx_push;
    logic [7:0]            tx_wdata;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  rx_pop;
    logic [7:0]            rx_head;
    logic                  rx_full;
    logic                  rx_empty;
    logic [7:0]            io_rdata;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^cpu_a[31:18];

    assign is_io    = (cpu_a[17:16] == 2'b11);
    assign ram_addr = cpu_a[ADDR_WIDTH-1:0];
    assign io_off   = cpu_a[15:0];
    assign cpu_rdy  = !tx_full;
    assign act      = cpu_rdy;
    assign io_wr    = act && cpu_wr && is_io;
    assign io_rd    = act && !cpu_wr && is_io;
    // Reset gating keeps a write presented during reset from landing in RAM.
    assign ram_we   = rst_n_in && act && cpu_wr && !is_io;

    // 0x30000 pushes non-zero bytes; 0x30004 always pushes a zero terminator.
    assign tx_push  = io_wr && (((io_off == 16'h0000) && (cpu_wdata != 8'h00)) || (io_off == 16'h0004));
    assign tx_wdata = (io_off == 16'h0004) ? 8'h00 : cpu_wdata;
    assign rx_pop   = io_rd && (io_off == 16'h0000) && !rx_empty;

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;

    mem_io_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    mem_io_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (tx_push),
        .wdata (tx_wdata),
        .pop   (tx_ready),
        .head  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

`ifdef MEM_IO_RESPONDER_CLK_CNT_EN
    logic [31:0] cnt;
    logic [23:0] snap;

    // Reading the low byte freezes the upper bytes so a 4-byte read is coherent.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt  <= '0;
            snap <= '0;
        end else begin
            cnt <= cnt + 32'd1;
            if (io_rd && (io_off == 16'h0004)) snap <= cnt[31:8];
        end
    end
`endif

    always_comb begin
        io_rdata = 8'h00;
        if (io_off == 16'h0000) begin
            io_rdata = rx_empty ? 8'h00 : rx_head;
        end
`ifdef MEM_IO_RESPONDER_CLK_CNT_EN
        else if (io_off[15:2] == 14'h0001) begin
            case (io_off[1:0])
                2'd0:    io_rdata = cnt[7:0];
                2'd1:    io_rdata = snap[7:0];
                2'd2:    io_rdata = snap[15:8];
                default: io_rdata = snap[23:16];
            endcase
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) mem[ram_addr] <= cpu_wdata;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cpu_rdata <= 8'h00;
            prog_stop <= 1'b0;
        end else begin
            if (act && !cpu_wr) cpu_rdata <= is_io ? io_rdata : mem[ram_addr];
            if (io_wr && (io_off == 16'h0004)) prog_stop <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: table of RAM/I/O bus vectors plus hand-written FIFO, counter and reset sequences.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        prog_stop;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  wd;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt [10];

    mem_io_responder dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .cpu_a     (cpu_a),
        .cpu_wdata (cpu_wdata),
        .cpu_wr    (cpu_wr),
        .cpu_rdata (cpu_rdata),
        .cpu_rdy   (cpu_rdy),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .prog_stop (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at a falling edge, return at the next falling edge with the bus idle.
    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] wd);
        cpu_a     = a;
        cpu_wr    = wr;
        cpu_wdata = wd;
        @(negedge clk_in);
        cpu_a     = 32'h0;
        cpu_wr    = 1'b0;
        cpu_wdata = 8'h00;
    endtask

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        rst_n_in  = 1'b0;
        cpu_a     = 32'h0;
        cpu_wdata = 8'h00;
        cpu_wr    = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;

        vt[0] = '{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00};
        vt[1] = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[2] = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00};
        vt[3] = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C};
        vt[4] = '{32'h0000_0124, 1'b1, 8'h5A, 1'b0, 8'h00};
        vt[5] = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[6] = '{32'h0000_0124, 1'b0, 8'h00, 1'b1, 8'h5A};
        vt[7] = '{32'h0003_0008, 1'b1, 8'h77, 1'b0, 8'h00};
        vt[8] = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00};
        vt[9] = '{32'h0002_0123, 1'b0, 8'h00, 1'b1, 8'hA5};

        repeat (3) @(negedge clk_in);
        check("reset_rdata", cpu_rdata, 8'h00);
        check("reset_tx_valid", tx_valid, 1'b0);
        check("reset_rx_ready", rx_ready, 1'b1);
        check("reset_cpu_rdy", cpu_rdy, 1'b1);
        check("reset_prog_stop", prog_stop, 1'b0);
        rst_n_in = 1'b1;

        // Counter: 254 rising edges after release the counter holds 0xFE.
        repeat (254) @(negedge clk_in);
`ifdef MEM_IO_RESPONDER_CLK_CNT_EN
        bus(32'h0003_0004, 1'b0, 8'h00); check("cnt_byte0", cpu_rdata, 8'hFE);
        bus(32'h0003_0005, 1'b0, 8'h00); check("cnt_byte1", cpu_rdata, 8'h00);
        bus(32'h0003_0006, 1'b0, 8'h00); check("cnt_byte2", cpu_rdata, 8'h00);
        bus(32'h0003_0007, 1'b0, 8'h00); check("cnt_byte3", cpu_rdata, 8'h00);
`else
        bus(32'h0003_0001, 1'b0, 8'h00);
        bus(32'h0003_0004, 1'b0, 8'h00); check("cnt_off_byte0", cpu_rdata, 8'h00);
        bus(32'h0003_0005, 1'b0, 8'h00); check("cnt_off_byte1", cpu_rdata, 8'h00);
        bus(32'h0003_0006, 1'b0, 8'h00); check("cnt_off_byte2", cpu_rdata, 8'h00);
        bus(32'h0003_0007, 1'b0, 8'h00); check("cnt_off_byte3", cpu_rdata, 8'h00);
`endif

        for (int i = 0; i < 10; i++) begin
            bus(vt[i].a, vt[i].wr, vt[i].wd);
            if (vt[i].chk) check($sformatf("vec%0d_rdata", i), cpu_rdata, vt[i].exp);
        end
        check("io_write_ignored_tx", tx_valid, 1'b0);

        // RX stream basic.
        rx_data = 8'h41; rx_valid = 1'b1; @(negedge clk_in);
        rx_data = 8'h42; @(negedge clk_in);
        rx_valid = 1'b0;
        check("rx_ready_two", rx_ready, 1'b1);
        bus(32'h0003_0000, 1'b0, 8'h00); check("rx_read0", cpu_rdata, 8'h41);
        bus(32'h0003_0000, 1'b0, 8'h00); check("rx_read1", cpu_rdata, 8'h42);
        bus(32'h0003_0000, 1'b0, 8'h00); check("rx_read_empty", cpu_rdata, 8'h00);

        // Push and pop in the same cycle on an empty FIFO: read sees 0, byte stays.
        rx_data = 8'h55; rx_valid = 1'b1;
        bus(32'h0003_0000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        check("rx_sim_empty_read", cpu_rdata, 8'h00);
        bus(32'h0003_0000, 1'b0, 8'h00); check("rx_sim_empty_kept", cpu_rdata, 8'h55);

        // Same on a non-empty FIFO: order is preserved.
        rx_data = 8'h61; rx_valid = 1'b1; @(negedge clk_in);
        rx_data = 8'h62;
        bus(32'h0003_0000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        check("rx_sim_busy_read0", cpu_rdata, 8'h61);
        bus(32'h0003_0000, 1'b0, 8'h00); check("rx_sim_busy_read1", cpu_rdata, 8'h62);

        // RX full: 16 bytes accepted, the 17th refused.
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'h10 + 8'(i);
            @(negedge clk_in);
        end
        check("rx_full_ready", rx_ready, 1'b0);
        rx_data = 8'hEE; @(negedge clk_in);
        rx_valid = 1'b0;
        bus(32'h0003_0000, 1'b0, 8'h00); check("rx_full_read0", cpu_rdata, 8'h10);
        check("rx_ready_after_pop", rx_ready, 1'b1);
        for (int i = 1; i < 16; i++) begin
            bus(32'h0003_0000, 1'b0, 8'h00);
            check($sformatf("rx_full_read%0d", i), cpu_rdata, 8'h10 + 8'(i));
        end
        bus(32'h0003_0000, 1'b0, 8'h00); check("rx_dropped_byte", cpu_rdata, 8'h00);

        // TX backpressure.
        tx_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            bus(32'h0003_0000, 1'b1, 8'(i));
            check($sformatf("tx_rdy_after_push%0d", i), cpu_rdy, (i == 16) ? 1'b0 : 1'b1);
        end
        bus(32'h0003_0000, 1'b1, 8'd17);
        check("tx_rdy_still_low", cpu_rdy, 1'b0);
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("tx_valid_%0d", i), tx_valid, 1'b1);
            check($sformatf("tx_data_%0d", i), tx_data, 8'(i));
            @(negedge clk_in);
            if (i == 1) check("tx_rdy_after_pop", cpu_rdy, 1'b1);
        end
        check("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Zero filter and stop.
        bus(32'h0003_0000, 1'b1, 8'h00);
        check("tx_zero_filtered", tx_valid, 1'b0);
        check("stop_before", prog_stop, 1'b0);
        bus(32'h0003_0004, 1'b1, 8'h99);
        check("stop_set", prog_stop, 1'b1);
        check("stop_tx_valid", tx_valid, 1'b1);
        check("stop_tx_data", tx_data, 8'h00);
        tx_ready = 1'b1; @(negedge clk_in); tx_ready = 1'b0;
        check("stop_tx_drained", tx_valid, 1'b0);
        check("stop_sticky", prog_stop, 1'b1);

        // Asynchronous reset mid-stream.
        bus(32'h0000_0200, 1'b1, 8'hC7);
        bus(32'h0003_0000, 1'b1, 8'h11);
        bus(32'h0003_0000, 1'b1, 8'h22);
        bus(32'h0003_0000, 1'b1, 8'h33);
        bus(32'h0000_0200, 1'b0, 8'h00); check("pre_reset_ram", cpu_rdata, 8'hC7);
        check("pre_reset_tx_valid", tx_valid, 1'b1);
        #2;
        rst_n_in  = 1'b0;
        cpu_a     = 32'h0000_0200;
        cpu_wr    = 1'b1;
        cpu_wdata = 8'hFF;
        #1;
        check("async_tx_valid", tx_valid, 1'b0);
        check("async_prog_stop", prog_stop, 1'b0);
        check("async_rdata", cpu_rdata, 8'h00);
        check("async_cpu_rdy", cpu_rdy, 1'b1);
        @(negedge clk_in);
        cpu_a = 32'h0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
        rst_n_in = 1'b1;
        bus(32'h0000_0200, 1'b0, 8'h00); check("ram_survives_reset", cpu_rdata, 8'hC7);
        check("post_reset_tx_valid", tx_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
